// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit count needs to reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fulladd.sv
// One-bit full adder cell shared across all bit positions of the serial add.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fulladd cell iterated over WIDTH cycles, LSB first.
// Optional signed-overflow output built only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_cat;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    fulladd u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_carry),
        .sum   (w_s),
        .carry (w_c)
    );

    // Only WIDTH-1 sum bits are stored; the final bit joins them as the result is latched.
    assign w_sum_cat = {w_s, r_sum_sr};

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a_sr   <= a;
                r_b_sr   <= b;
                r_carry  <= cin;
                r_cnt    <= '0;
                r_sum_sr <= '0;
            end else if (busy) begin
                r_a_sr   <= r_a_sr >> 1;
                r_b_sr   <= r_b_sr >> 1;
                r_carry  <= w_c;
                r_cnt    <= r_cnt + 1'b1;
                r_sum_sr <= w_sum_cat[WIDTH-1:1];
            end
            // Results become visible only on the edge that enters DONE.
            if (w_last) begin
                r_sum  <= w_sum_cat;
                r_cout <= w_c;
`ifdef SERIAL_ADD_OVF_EN
                r_ovf  <= r_carry ^ w_c;
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl (WIDTH=8); ovf checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for done; lat counts cycles after the accepting edge.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output int lat, output int bcnt, output bit tmo);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0; tmo = 1'b1;
        repeat (40) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            bad++;
            $display("FAIL reset_state busy=%b done=%b cout=%b sum=%h expected all zero", busy, done, cout, sum);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        bit tmo;
        logic [W-1:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'hA5};
        logic [W-1:0] vb [4] = '{8'h00, 8'h01, 8'h01, 8'h5A};
        logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W:0]   ve [4] = '{9'h000, 9'h100, 9'h080, 9'h100};
        logic         vo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], lat, bcnt, tmo);
            total++;
            if (tmo || lat !== W + 1) begin
                bad++;
                $display("FAIL basic_latency[%0d] got=%0d timeout=%0b expected=%0d", i, lat, tmo, W + 1);
            end
            total++;
            if (bcnt !== W) begin
                bad++;
                $display("FAIL basic_busy_cycles[%0d] got=%0d expected=%0d", i, bcnt, W);
            end
            total++;
            if ({cout, sum} !== ve[i]) begin
                bad++;
                $display("FAIL basic_result[%0d] got=%h expected=%h", i, {cout, sum}, ve[i]);
            end
`ifdef SERIAL_ADD_OVF_EN
            total++;
            if (ovf !== vo[i]) begin
                bad++;
                $display("FAIL basic_ovf[%0d] got=%b expected=%b", i, ovf, vo[i]);
            end
`else
            if (vo[i] === 1'bx) $display("unused ovf vector entry %0d", i);
`endif
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit tmo;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; tmo = 1'b1;
        repeat (40) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (lat == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++;
        if (tmo || lat !== W + 1) begin
            bad++;
            $display("FAIL ignore_latency got=%0d timeout=%0b expected=%0d", lat, tmo, W + 1);
        end
        total++;
        if ({cout, sum} !== 9'h046) begin
            bad++;
            $display("FAIL ignore_result got=%h expected=046", {cout, sum});
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_requeue busy=%b expected=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, dcnt;
        bit tmo;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            bad++;
            $display("FAIL midreset_state busy=%b done=%b cout=%b sum=%h expected all zero", busy, done, cout, sum);
        end
        dcnt = 0;
        repeat (12) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        total++;
        if (dcnt !== 0) begin
            bad++;
            $display("FAIL midreset_no_done active_cycles=%0d expected=0", dcnt);
        end
        do_op(8'h10, 8'h20, 1'b1, lat, bcnt, tmo);
        total++;
        if (tmo || lat !== W + 1 || {cout, sum} !== 9'h031) begin
            bad++;
            $display("FAIL midreset_recover lat=%0d timeout=%0b result=%h expected lat=%0d result=031",
                     lat, tmo, {cout, sum}, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{8'h3C, 8'h80, 8'h55};
        logic [W-1:0] vb [3] = '{8'h0F, 8'h80, 8'hAA};
        logic         vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   ve [3] = '{9'h04B, 9'h101, 9'h0FF};
        logic [W:0]   held;
        int lat, herr;
        bit tmo;
        @(negedge clk);
        a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
        held = {cout, sum};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lat = 1; tmo = 1'b1; herr = 0;
            repeat (40) begin
                if (done) begin
                    tmo = 1'b0;
                    break;
                end
                if ({cout, sum} !== held) herr++;
                @(negedge clk);
                lat++;
            end
            total++;
            if (tmo || lat !== W + 1) begin
                bad++;
                $display("FAIL b2b_period[%0d] got=%0d timeout=%0b expected=%0d", k, lat, tmo, W + 1);
            end
            total++;
            if (herr !== 0) begin
                bad++;
                $display("FAIL b2b_hold[%0d] changed_cycles=%0d expected=0", k, herr);
            end
            total++;
            if ({cout, sum} !== ve[k]) begin
                bad++;
                $display("FAIL b2b_result[%0d] got=%h expected=%h", k, {cout, sum}, ve[k]);
            end
            held = ve[k];
            if (k < 2) begin
                a = va[k+1]; b = vb[k+1]; cin = vc[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit tmo;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   exp_v;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, lat, bcnt, tmo);
            total++;
            if (tmo || {cout, sum} !== exp_v) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b got=%h timeout=%0b expected=%h",
                         i, ra, rb, rc, {cout, sum}, tmo, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
